// File: rtl/wb_seg_cache_perf_pkg.sv
// wb_perf_pkg: shared types for the MEM/WB segment and its data-cache performance counters
//   perf_sel_e : counter slot / select code (rd-hit, rd-miss, wr-hit, wr-miss)
//   state_e    : access-classification FSM states
package wb_perf_pkg;
   typedef enum logic [1:0] {RD_HIT, RD_MISS, WR_HIT, WR_MISS} perf_sel_e;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   // A store takes the write slots even when a load is requested in the same cycle
   function automatic perf_sel_e perf_slot(input logic wr, input logic miss);
      return perf_sel_e'({wr, miss});
   endfunction
endpackage

// File: rtl/wb_seg_cache_perf_if.sv
// wb_seg_cache_perf_if: data-cache port between the MEM/WB segment (master) and the cache (slave)
//   cache_addr/cache_wdata : request address and store data
//   cache_wr_req/rd_req    : store / load request
//   cache_rdata/cache_miss : returned load data and busy/miss flag
interface wb_seg_cache_perf_if #(parameter int DATA_W = 32);
   logic [DATA_W-1:0] cache_addr, cache_wdata, cache_rdata;
   logic              cache_wr_req, cache_rd_req, cache_miss;
   modport master (output cache_addr, cache_wdata, cache_wr_req, cache_rd_req,
                   input  cache_rdata, cache_miss);
   modport slave  (input  cache_addr, cache_wdata, cache_wr_req, cache_rd_req,
                   output cache_rdata, cache_miss);
endinterface

// File: rtl/wb_seg_cache_perf_counter.sv
// perf_counter_sat: saturating event counter
//   clk, rst (async, active-high) ; inc : count one event ; clr : sync clear, beats inc
//   cnt : current count, sticks at all-ones
module perf_counter_sat #(parameter int CNT_W = 32) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/wb_seg_cache_perf.sv
// wb_seg_cache_perf: MEM/WB segment register with data-cache port, stall-stable load data and hit/miss counters
//   clk, rst (async, active-high), en (0 = stall), clear (sync flush of WB regs)
//   MEM inputs : a_m, wd_m, we_m, mem_to_reg_m, result_m, rd_m, reg_write_m
//   cache      : master side of the data-cache port; cache_miss_o mirrors the miss flag for the hazard unit
//   WB outputs : rd_w_data, lbs_w, result_w, rd_w, reg_write_w, mem_to_reg_w
//   perf       : perf_sel picks a counter onto perf_cnt; perf_clr clears all four
module wb_seg_cache_perf
   import wb_perf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int RW_W   = 3,
   parameter int CNT_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clear,
   input  logic [DATA_W-1:0]   a_m,
   input  logic [DATA_W-1:0]   wd_m,
   input  logic [3:0]          we_m,
   input  logic                mem_to_reg_m,
   input  logic [DATA_W-1:0]   result_m,
   input  logic [RD_W-1:0]     rd_m,
   input  logic [RW_W-1:0]     reg_write_m,
   wb_seg_cache_perf_if.master cache,
   output logic                cache_miss_o,
   output logic [DATA_W-1:0]   rd_w_data,
   output logic [1:0]          lbs_w,
   output logic [DATA_W-1:0]   result_w,
   output logic [RD_W-1:0]     rd_w,
   output logic [RW_W-1:0]     reg_write_w,
   output logic                mem_to_reg_w,
   input  logic [1:0]          perf_sel,
   input  logic                perf_clr,
   output logic [CNT_W-1:0]    perf_cnt
);
   logic [DATA_W-1:0] hold_data;
   logic              hold_valid;
   logic              access;
   logic [3:0]        inc;
   logic [CNT_W-1:0]  cnt [4];
   state_e            state;

   assign cache.cache_addr   = a_m;
   assign cache.cache_wdata  = wd_m;
   assign cache.cache_wr_req = |we_m;
   assign cache.cache_rd_req = mem_to_reg_m;
   assign cache_miss_o       = cache.cache_miss;
   assign rd_w_data          = hold_valid ? hold_data : cache.cache_rdata;
   assign access             = cache.cache_rd_req | cache.cache_wr_req;
   // Only IDLE classifies, so each access bumps exactly one counter once
   assign inc = (state == IDLE && access) ? 4'b0001 << perf_slot(cache.cache_wr_req, cache.cache_miss) : 4'b0000;
   assign perf_cnt = cnt[perf_sel];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {lbs_w, result_w, rd_w, reg_write_w, mem_to_reg_w} <= '0;
         hold_data  <= '0;
         hold_valid <= 1'b0;
      end else begin
         if (clear) {lbs_w, result_w, rd_w, reg_write_w, mem_to_reg_w} <= '0;
         else if (en) {lbs_w, result_w, rd_w, reg_write_w, mem_to_reg_w} <= {a_m[1:0], result_m, rd_m, reg_write_m, mem_to_reg_m};
         // Capture the load data on the first stalled edge so WB sees it stable while the cache moves on
         if (clear || en) hold_valid <= 1'b0;
         else if (!hold_valid) begin
            hold_data  <= cache.cache_rdata;
            hold_valid <= 1'b1;
         end
      end

   // A hit taken while stalled goes to DONE so the same access is not re-counted before it retires
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else case (state)
         IDLE:    if (access) state <= cache.cache_miss ? BUSY : (en ? IDLE : DONE);
         BUSY:    if (!cache.cache_miss) state <= DONE;
         default: if (en) state <= IDLE;
      endcase

   for (genvar i = 0; i < 4; i++) begin : g_cnt
      perf_counter_sat #(.CNT_W(CNT_W)) u_cnt (
         .clk(clk), .rst(rst), .inc(inc[i]), .clr(perf_clr), .cnt(cnt[i])
      );
   end
endmodule

// File: tb/tb_wb_seg_cache_perf.sv
// tb_wb_seg_cache_perf: directed bench for wb_seg_cache_perf with a behavioural reference model
module tb_wb_seg_cache_perf;
   import wb_perf_pkg::*;

   logic        clk = 1'b0, rst = 1'b1;
   logic        en, clear, mem_to_reg_m, perf_clr, miss;
   logic [31:0] a_m, wd_m, result_m, rdata;
   logic [3:0]  we_m;
   logic [4:0]  rd_m;
   logic [2:0]  reg_write_m;
   logic [1:0]  perf_sel;

   logic        miss_o, m2r_w, miss_o4, m2r_w4;
   logic [31:0] rdw, res_w, rdw4, res_w4, cnt32;
   logic [1:0]  lbs_w, lbs_w4;
   logic [4:0]  rd_w, rd_w4;
   logic [2:0]  rw_w, rw_w4;
   logic [3:0]  cnt4;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   wb_seg_cache_perf_if #(.DATA_W(32)) bus ();
   wb_seg_cache_perf_if #(.DATA_W(32)) bus4 ();
   assign bus.cache_rdata  = rdata;
   assign bus.cache_miss   = miss;
   assign bus4.cache_rdata = rdata;
   assign bus4.cache_miss  = miss;

   wb_seg_cache_perf #(.DATA_W(32), .RD_W(5), .RW_W(3), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .a_m(a_m), .wd_m(wd_m), .we_m(we_m),
      .mem_to_reg_m(mem_to_reg_m), .result_m(result_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .cache(bus), .cache_miss_o(miss_o), .rd_w_data(rdw), .lbs_w(lbs_w), .result_w(res_w),
      .rd_w(rd_w), .reg_write_w(rw_w), .mem_to_reg_w(m2r_w), .perf_sel(perf_sel),
      .perf_clr(perf_clr), .perf_cnt(cnt32));

   wb_seg_cache_perf #(.DATA_W(32), .RD_W(5), .RW_W(3), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .a_m(a_m), .wd_m(wd_m), .we_m(we_m),
      .mem_to_reg_m(mem_to_reg_m), .result_m(result_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .cache(bus4), .cache_miss_o(miss_o4), .rd_w_data(rdw4), .lbs_w(lbs_w4), .result_w(res_w4),
      .rd_w(rd_w4), .reg_write_w(rw_w4), .mem_to_reg_w(m2r_w4), .perf_sel(perf_sel),
      .perf_clr(perf_clr), .perf_cnt(cnt4));

   // Reference model: WB registers, held load data, and per-event counts with an
   // "already classified" notion (waiting for the miss to resolve / waiting for retirement)
   logic [31:0] e_hd, e_res;
   logic        e_hv, e_m2r;
   logic [1:0]  e_lbs;
   logic [4:0]  e_rd;
   logic [2:0]  e_rw;
   longint      c32 [4];
   int          c4 [4];
   bit          miss_pending, await_retire;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         {e_hd, e_res, e_hv, e_m2r, e_lbs, e_rd, e_rw} = '0;
         for (int i = 0; i < 4; i++) begin c32[i] = 0; c4[i] = 0; end
         miss_pending = 0;
         await_retire = 0;
      end else begin
         bit wr, acc;
         int k;
         wr  = |we_m;
         acc = wr | mem_to_reg_m;
         k   = (wr ? 2 : 0) + (miss ? 1 : 0);
         if (!miss_pending && !await_retire && acc) begin
            if (c32[k] < 64'h0000_0000_FFFF_FFFF) c32[k]++;
            if (c4[k] < 15) c4[k]++;
            if (miss) miss_pending = 1;
            else if (!en) await_retire = 1;
         end else if (miss_pending) begin
            if (!miss) begin miss_pending = 0; await_retire = 1; end
         end else if (await_retire && en) await_retire = 0;
         if (perf_clr) for (int i = 0; i < 4; i++) begin c32[i] = 0; c4[i] = 0; end
         if (clear || en) e_hv = 0;
         else if (!e_hv) begin e_hd = rdata; e_hv = 1; end
         if (clear) {e_lbs, e_res, e_rd, e_rw, e_m2r} = '0;
         else if (en) {e_lbs, e_res, e_rd, e_rw, e_m2r} = {a_m[1:0], result_m, rd_m, reg_write_m, mem_to_reg_m};
      end
   end

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic rd_cnt(input logic [1:0] s, input longint e32, input int e4, input string nm);
      perf_sel = s;
      @(negedge clk);
      chk({nm, "_model"}, c32[s], e32);
      chk({nm, "_cnt"}, cnt32, e32);
      chk({nm, "_cnt4"}, cnt4, e4);
      tick();
   endtask

   // Every-cycle comparison against the model
   initial begin
      logic [31:0] exp_rdw;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_rdw = e_hv ? e_hd : rdata;
         chk("cache_addr", bus.cache_addr, a_m);
         chk("cache_wdata", bus.cache_wdata, wd_m);
         chk("cache_req", {bus.cache_wr_req, bus.cache_rd_req}, {|we_m, mem_to_reg_m});
         chk("cache_miss_o", miss_o, miss);
         chk("rd_w_data", rdw, exp_rdw);
         chk("wb_regs", {lbs_w, res_w, rd_w, rw_w, m2r_w}, {e_lbs, e_res, e_rd, e_rw, e_m2r});
         chk("perf_cnt", cnt32, c32[perf_sel]);
         chk("perf_cnt4", cnt4, c4[perf_sel]);
         chk("dut4_outputs",
             {bus4.cache_addr, bus4.cache_wdata, bus4.cache_wr_req, bus4.cache_rd_req, miss_o4, rdw4, lbs_w4, res_w4, rd_w4, rw_w4, m2r_w4},
             {a_m, wd_m, |we_m, mem_to_reg_m, miss, exp_rdw, e_lbs, e_res, e_rd, e_rw, e_m2r});
      end
   end

   initial begin
      en = 1; clear = 0; mem_to_reg_m = 0; perf_clr = 0; miss = 0;
      a_m = 0; wd_m = 0; result_m = 0; rdata = 32'h55; we_m = 0; rd_m = 0; reg_write_m = 0; perf_sel = 0;
      tick(); tick();
      rst = 0;
      for (int s = 0; s < 4; s++) rd_cnt(2'(s), 0, 0, "reset");
      // three back-to-back load hits
      mem_to_reg_m = 1;
      for (int i = 0; i < 3; i++) begin
         a_m = 32'h100 + 32'(4 * i) + 32'(i); result_m = 32'(i + 10); rd_m = 5'(i + 1); reg_write_m = 3'd1; rdata = 32'(i + 32'hA0);
         tick();
      end
      mem_to_reg_m = 0;
      rd_cnt(RD_HIT, 3, 3, "rd_hit3");
      rd_cnt(RD_MISS, 0, 0, "rd_miss0");
      // store miss held 10 cycles while stalled
      a_m = 32'h40; wd_m = 32'hDEAD_BEEF; we_m = 4'hF; en = 0; miss = 1;
      repeat (10) tick();
      miss = 0; tick();
      en = 1; tick();
      we_m = 0;
      rd_cnt(WR_MISS, 1, 1, "wr_miss1");
      rd_cnt(WR_HIT, 0, 0, "wr_hit0");
      // load and store together count as a write
      we_m = 4'h3; mem_to_reg_m = 1; tick();
      we_m = 0; mem_to_reg_m = 0;
      rd_cnt(WR_HIT, 1, 1, "both_wr");
      rd_cnt(RD_HIT, 3, 3, "both_not_rd");
      // stall keeps load data stable
      rdata = 32'h11; en = 1; tick();
      en = 0; tick();
      rdata = 32'h22;
      @(negedge clk); chk("hold_stall1", rdw, 32'h11); tick();
      @(negedge clk); chk("hold_stall2", rdw, 32'h11); tick();
      en = 1; tick();
      @(negedge clk); chk("hold_release", rdw, 32'h22); tick();
      // flush while stalled
      rd_m = 5'd7; reg_write_m = 3'd3; result_m = 32'h1234; a_m = 32'h3; tick();
      @(negedge clk); chk("pre_clear_rd", rd_w, 5'd7); chk("pre_clear_rw", rw_w, 3'd3); tick();
      en = 0; clear = 1; tick();
      clear = 0;
      @(negedge clk); chk("clear_rd", rd_w, 0); chk("clear_rw", rw_w, 0); chk("clear_res", res_w, 0); tick();
      en = 1;
      // saturation of the narrow counter
      perf_clr = 1; tick();
      perf_clr = 0; mem_to_reg_m = 1;
      repeat (17) tick();
      mem_to_reg_m = 0;
      rd_cnt(RD_HIT, 17, 15, "sat");
      // clear beats a same-cycle hit
      perf_clr = 1; mem_to_reg_m = 1; tick();
      perf_clr = 0; mem_to_reg_m = 0;
      rd_cnt(RD_HIT, 0, 0, "clr_vs_inc");
      // a hit seen while stalled counts once
      mem_to_reg_m = 1; en = 0;
      repeat (3) tick();
      en = 1; tick();
      mem_to_reg_m = 0;
      rd_cnt(RD_HIT, 1, 1, "stalled_hit");
      // reset in the middle of a load miss
      mem_to_reg_m = 1; miss = 1; en = 0; tick();
      rd_cnt(RD_MISS, 1, 1, "pre_rst_miss");
      rst = 1;
      for (int s = 0; s < 4; s++) rd_cnt(2'(s), 0, 0, "in_rst");
      @(negedge clk); chk("rst_result", res_w, 0); chk("rst_rd", rd_w, 0); tick();
      rst = 0; tick();
      miss = 0; tick();
      en = 1; tick();
      mem_to_reg_m = 0;
      rd_cnt(RD_MISS, 1, 1, "refresh_miss");
      rd_cnt(RD_HIT, 0, 0, "refresh_hit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
